// File: rtl/move_scheduler.sv
// Move scheduler: edge-detects button/pad/debug move requests, queues them in a small FIFO,
// hands them to game_logic one at a time and strobes the grid commit once each move finishes.
module move_scheduler #(
   parameter int DEPTH           = 4,
   parameter int TIMEOUT         = 1024,
   parameter bit COMMIT_ON_VSYNC = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [3:0]               btn_dir,
   input  logic [3:0]               pad_dir,
   input  logic                     pad_present,
   input  logic [3:0]               dbg_move,
   input  logic                     vsync,
   output logic                     move_valid,
   output logic [1:0]               move_dir,
   input  logic                     move_ready,
   input  logic                     move_done,
   output logic                     grid_commit,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow,
   output logic                     timeout_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, BUSY, WAIT_VS} state_t;

   function automatic logic [1:0] lowest_dir(input logic [3:0] v);
      if (v[0])      return 2'd0;
      else if (v[1]) return 2'd1;
      else if (v[2]) return 2'd2;
      else           return 2'd3;
   endfunction

   // Previous-sample registers run through reset so levels held across reset never fire.
   logic [3:0] btn_prev_reg, pad_prev_reg, dbg_prev_reg;
   logic       vsync_prev_reg;

   always_ff @(posedge clk) begin
      btn_prev_reg   <= btn_dir;
      pad_prev_reg   <= pad_dir;
      dbg_prev_reg   <= dbg_move;
      vsync_prev_reg <= vsync;
   end

   // Source slots in priority order: 0 = debug, 1 = pad, 2 = buttons.
   logic [2:0][3:0] src_rise;
   logic [2:0]      src_hit;
   logic [2:0][1:0] src_code;

   assign src_rise[0] = dbg_move & ~dbg_prev_reg;
   assign src_rise[1] = (pad_present && enable) ? (pad_dir & ~pad_prev_reg) : 4'b0000;
   assign src_rise[2] = enable ? (btn_dir & ~btn_prev_reg) : 4'b0000;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_src
         assign src_hit[gi]  = |src_rise[gi];
         assign src_code[gi] = lowest_dir(src_rise[gi]);
      end
   endgenerate

   logic       evt_valid;
   logic [1:0] evt_dir;
   logic       evt_lost;

   always_comb begin
      evt_valid = 1'b0;
      evt_dir   = 2'd0;
      evt_lost  = 1'b0;
      if (src_hit[0]) begin
         evt_valid = 1'b1;
         evt_dir   = src_code[0];
         evt_lost  = src_hit[1] | src_hit[2];
      end else if (src_hit[1]) begin
         evt_valid = 1'b1;
         evt_dir   = src_code[1];
         evt_lost  = src_hit[2];
      end else if (src_hit[2]) begin
         evt_valid = 1'b1;
         evt_dir   = src_code[2];
      end
   end

   logic [1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]   count_reg;
   logic          overflow_reg;
   state_t        state_reg, state_next;

   logic fifo_full, pop, push, drop;

   assign fifo_full = (count_reg == (AW+1)'(DEPTH));
   assign pop       = (state_reg == ISSUE) && move_ready;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign push      = evt_valid && (!fifo_full || pop);
   assign drop      = evt_valid && fifo_full && !pop;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= evt_dir;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
         if (evt_lost || drop) overflow_reg <= 1'b1;
      end
   end

   logic [TW-1:0] cnt_reg, cnt_next;
   logic          commit_reg, commit_next;
   logic          timeout_reg, tmo_set;
   logic          dir_load;
   logic [1:0]    dir_reg;

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      commit_next = 1'b0;
      tmo_set     = 1'b0;
      dir_load    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (count_reg != '0) begin
               state_next = ISSUE;
               dir_load   = 1'b1;
            end
         end
         ISSUE: begin
            if (move_ready) begin
               state_next = BUSY;
               cnt_next   = '0;
            end
         end
         BUSY: begin
            if (move_done) begin
               if (COMMIT_ON_VSYNC) begin
                  state_next = WAIT_VS;
               end else begin
                  state_next  = IDLE;
                  commit_next = 1'b1;
               end
            end else if (TIMEOUT != 0 && cnt_reg == TW'(TIMEOUT - 1)) begin
               state_next = IDLE;
               tmo_set    = 1'b1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         WAIT_VS: begin
            if (vsync && !vsync_prev_reg) begin
               state_next  = IDLE;
               commit_next = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Head is read into a register on IDLE->ISSUE so move_dir stays put during the handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         commit_reg  <= 1'b0;
         timeout_reg <= 1'b0;
         dir_reg     <= 2'd0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         commit_reg <= commit_next;
         if (tmo_set)  timeout_reg <= 1'b1;
         if (dir_load) dir_reg     <= mem[rd_ptr_reg];
      end
   end

   assign move_valid  = (state_reg == ISSUE);
   assign move_dir    = dir_reg;
   assign grid_commit = commit_reg;
   assign fifo_count  = count_reg;
   assign overflow    = overflow_reg;
   assign timeout_err = timeout_reg;

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler: DEPTH=4, TIMEOUT=8, plus an immediate-commit instance.
module tb_move_scheduler;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [3:0] btn_dir = 4'b0, pad_dir = 4'b0, dbg_move = 4'b0;
   logic       pad_present = 1'b0;
   logic       vsync = 1'b0;
   logic       move_ready = 1'b0, move_done = 1'b0;

   logic       move_valid, grid_commit, overflow, timeout_err;
   logic [1:0] move_dir;
   logic [2:0] fifo_count;

   logic       nv_move_valid, nv_grid_commit, nv_overflow, nv_timeout_err;
   logic [1:0] nv_move_dir;
   logic [2:0] nv_fifo_count;

   int total = 0;
   int bad   = 0;
   int commits;

   always #5 clk = ~clk;

   move_scheduler #(.DEPTH(4), .TIMEOUT(8), .COMMIT_ON_VSYNC(1'b1)) u_dut (
      .clk(clk), .reset(reset), .enable(enable), .btn_dir(btn_dir), .pad_dir(pad_dir),
      .pad_present(pad_present), .dbg_move(dbg_move), .vsync(vsync),
      .move_valid(move_valid), .move_dir(move_dir), .move_ready(move_ready),
      .move_done(move_done), .grid_commit(grid_commit), .fifo_count(fifo_count),
      .overflow(overflow), .timeout_err(timeout_err)
   );

   move_scheduler #(.DEPTH(4), .TIMEOUT(8), .COMMIT_ON_VSYNC(1'b0)) u_dut_nv (
      .clk(clk), .reset(reset), .enable(enable), .btn_dir(btn_dir), .pad_dir(pad_dir),
      .pad_present(pad_present), .dbg_move(dbg_move), .vsync(vsync),
      .move_valid(nv_move_valid), .move_dir(nv_move_dir), .move_ready(move_ready),
      .move_done(move_done), .grid_commit(nv_grid_commit), .fifo_count(nv_fifo_count),
      .overflow(nv_overflow), .timeout_err(nv_timeout_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      btn_dir = 4'b0; pad_dir = 4'b0; dbg_move = 4'b0;
      move_ready = 1'b0; move_done = 1'b0; vsync = 1'b0;
      step(); step();
      reset = 1'b0;
      enable = 1'b1;
   endtask

   task automatic press(input logic [3:0] v);
      btn_dir = v;
      step();
      btn_dir = 4'b0;
      step();
   endtask

   // Expects the FSM in ISSUE; finishes the move through a vsync commit.
   task automatic complete_move(input string tag, input logic [1:0] exp_dir);
      check({tag, "_valid"}, 32'(move_valid), 1);
      check({tag, "_dir"}, 32'(move_dir), 32'(exp_dir));
      move_ready = 1'b1;
      step();
      move_ready = 1'b0;
      check({tag, "_valid_drop"}, 32'(move_valid), 0);
      move_done = 1'b1;
      step();
      move_done = 1'b0;
      check({tag, "_no_early_commit"}, 32'(grid_commit), 0);
      vsync = 1'b1;
      step();
      check({tag, "_commit"}, 32'(grid_commit), 1);
      vsync = 1'b0;
      step();
      check({tag, "_commit_end"}, 32'(grid_commit), 0);
   endtask

   initial begin
      step(); step(); step();
      check("rst_valid", 32'(move_valid), 0);
      check("rst_dir", 32'(move_dir), 0);
      check("rst_commit", 32'(grid_commit), 0);
      check("rst_count", 32'(fifo_count), 0);
      check("rst_overflow", 32'(overflow), 0);
      check("rst_timeout", 32'(timeout_err), 0);
      reset = 1'b0;

      // Single button up with move_ready held high.
      enable = 1'b1; move_ready = 1'b1; btn_dir = 4'b0001;
      step();
      check("t1_count", 32'(fifo_count), 1);
      check("t1_valid_early", 32'(move_valid), 0);
      step();
      check("t1_valid", 32'(move_valid), 1);
      check("t1_dir", 32'(move_dir), 0);
      step();
      btn_dir = 4'b0;
      check("t1_valid_drop", 32'(move_valid), 0);
      check("t1_count_pop", 32'(fifo_count), 0);
      move_ready = 1'b0;
      move_done = 1'b1;
      step();
      move_done = 1'b0;
      check("t1_wait_vs_no_commit", 32'(grid_commit), 0);
      check("t1_nv_commit", 32'(nv_grid_commit), 1);
      step();
      check("t1_nv_commit_end", 32'(nv_grid_commit), 0);
      commits = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         commits += int'(grid_commit);
      end
      check("t1_no_commit_before_vs", commits, 0);
      vsync = 1'b1;
      step();
      check("t1_commit", 32'(grid_commit), 1);
      commits = 1;
      for (int i = 0; i < 8; i++) begin
         vsync = (i >= 4);
         step();
         commits += int'(grid_commit);
      end
      check("t1_one_commit", commits, 1);
      vsync = 1'b0;
      step();

      // Three sources rising together: debug wins, the others are overflow.
      dbg_move = 4'b0100; pad_dir = 4'b0010; btn_dir = 4'b1000; pad_present = 1'b1;
      step();
      dbg_move = 4'b0; pad_dir = 4'b0; btn_dir = 4'b0;
      check("t2_count", 32'(fifo_count), 1);
      check("t2_overflow", 32'(overflow), 1);
      step();
      complete_move("t2", 2'd2);
      check("t2_count_end", 32'(fifo_count), 0);

      // FIFO full, drop, then simultaneous push+pop while full, with pointer wrap.
      do_reset();
      press(4'b0001); press(4'b0010); press(4'b0100); press(4'b1000);
      check("t3_count_full", 32'(fifo_count), 4);
      check("t3_no_overflow_yet", 32'(overflow), 0);
      check("t3_head_dir", 32'(move_dir), 0);
      press(4'b0001);
      check("t3_count_drop", 32'(fifo_count), 4);
      check("t3_overflow", 32'(overflow), 1);
      btn_dir = 4'b0010; move_ready = 1'b1;
      step();
      btn_dir = 4'b0; move_ready = 1'b0;
      check("t3_full_push_pop", 32'(fifo_count), 4);
      move_done = 1'b1;
      step();
      move_done = 1'b0;
      vsync = 1'b1;
      step();
      check("t3_commit0", 32'(grid_commit), 1);
      vsync = 1'b0;
      step();
      complete_move("t3_m1", 2'd1);
      complete_move("t3_m2", 2'd2);
      complete_move("t3_m3", 2'd3);
      complete_move("t3_m4", 2'd1);
      check("t3_empty", 32'(fifo_count), 0);
      check("t3_idle", 32'(move_valid), 0);

      // Welcome screen: btn/pad ignored, debug accepted.
      do_reset();
      enable = 1'b0; pad_present = 1'b1;
      btn_dir = 4'b0001; pad_dir = 4'b0010;
      step();
      check("t4_gated_count", 32'(fifo_count), 0);
      check("t4_gated_overflow", 32'(overflow), 0);
      step();
      check("t4_gated_valid", 32'(move_valid), 0);
      btn_dir = 4'b0; pad_dir = 4'b0; dbg_move = 4'b0001;
      step();
      dbg_move = 4'b0;
      check("t4_dbg_count", 32'(fifo_count), 1);
      step();
      complete_move("t4", 2'd0);
      enable = 1'b1;

      // BUSY timeout after 8 cycles, no commit.
      do_reset();
      press(4'b0100);
      check("t5_valid", 32'(move_valid), 1);
      check("t5_dir", 32'(move_dir), 2);
      move_ready = 1'b1;
      step();
      move_ready = 1'b0;
      commits = 0;
      for (int i = 0; i < 7; i++) begin
         vsync = ~vsync;
         step();
         commits += int'(grid_commit);
      end
      check("t5_no_timeout_at_7", 32'(timeout_err), 0);
      step();
      check("t5_timeout", 32'(timeout_err), 1);
      for (int i = 0; i < 4; i++) begin
         vsync = ~vsync;
         step();
         commits += int'(grid_commit);
      end
      vsync = 1'b0;
      check("t5_no_commit", commits, 0);
      check("t5_idle", 32'(move_valid), 0);

      // Reset while waiting for vsync with two moves queued.
      do_reset();
      press(4'b0010); press(4'b0100); press(4'b1000);
      check("t6_count3", 32'(fifo_count), 3);
      move_ready = 1'b1;
      step();
      move_ready = 1'b0;
      move_done = 1'b1;
      step();
      move_done = 1'b0;
      check("t6_count2", 32'(fifo_count), 2);
      check("t6_dir_before", 32'(move_dir), 1);
      btn_dir = 4'b0001;
      reset = 1'b1;
      step();
      check("t6_rst_valid", 32'(move_valid), 0);
      check("t6_rst_dir", 32'(move_dir), 0);
      check("t6_rst_commit", 32'(grid_commit), 0);
      check("t6_rst_count", 32'(fifo_count), 0);
      vsync = 1'b1;
      step();
      check("t6_rst_vs_commit", 32'(grid_commit), 0);
      reset = 1'b0;
      vsync = 1'b0;
      commits = 0;
      for (int i = 0; i < 5; i++) begin
         vsync = (i == 2);
         step();
         commits += int'(grid_commit);
      end
      check("t6_no_commit", commits, 0);
      check("t6_held_btn_count", 32'(fifo_count), 0);
      check("t6_held_btn_valid", 32'(move_valid), 0);
      btn_dir = 4'b0;
      step();
      press(4'b1000);
      check("t6_after_valid", 32'(move_valid), 1);
      check("t6_after_dir", 32'(move_dir), 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
